instruction_fetch: RTL and testbench

Fetch stage of the RV32IM core. Owns the program counter, drives the combinational program ROM address, and captures the returned word into the IF/ID pipeline register for decode. It handles decode/execute stalls and taken-branch redirects, and can optionally predict backward conditional branches (loops) as taken.

---
 rtl/instruction_fetch.sv | 74 +++++++
 tb/tb_instruction_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Define FETCH_BTFN_PREDICT_EN to predict backward conditional branches as taken.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_pred_taken
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pred;
    logic        if_valid_q;
    logic        flush_q;

`ifdef FETCH_BTFN_PREDICT_EN
    logic        is_branch;
    logic [31:0] b_imm;

    always_comb begin
        is_branch = (rom_data[6:0] == 7'b1100011);
        b_imm     = {{19{rom_data[31]}}, rom_data[31], rom_data[7], rom_data[30:25],
                     rom_data[11:8], 1'b0};
        // Backward (negative offset) branches are assumed to be loop back-edges.
        pred      = is_branch && b_imm[12];
        next_pc   = pred ? (pc + b_imm) : (pc + 32'd4);
    end
`else
    always_comb begin
        pred    = 1'b0;
        next_pc = pc + 32'd4;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            if_pc         <= 32'h0000_0000;
            if_inst       <= NOP_INST;
            if_valid_q    <= 1'b0;
            if_pred_taken <= 1'b0;
            flush_q       <= 1'b0;
        end else if (redirect) begin
            // The word fetched this cycle is on the wrong path: replace it with a bubble.
            pc            <= {redirect_pc[31:2], 2'b00};
            if_pc         <= pc;
            if_inst       <= NOP_INST;
            if_valid_q    <= 1'b0;
            if_pred_taken <= 1'b0;
            flush_q       <= 1'b1;
        end else if (!stall) begin
            pc            <= next_pc;
            if_pc         <= pc;
            if_inst       <= rom_data;
            if_valid_q    <= 1'b1;
            if_pred_taken <= pred;
            flush_q       <= 1'b0;
        end
    end

    assign rom_addr = pc;
    assign if_valid = if_valid_q & ~flush_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: scoreboard of expected IF/ID contents.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_pred_taken;

    int errors = 0;
    int checks = 0;

    logic [65:0] exp_q[$];
    logic [31:0] exp_pc;

`ifdef FETCH_BTFN_PREDICT_EN
    localparam bit PredEn = 1'b1;
`else
    localparam bit PredEn = 1'b0;
`endif

    instruction_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid),
        .if_pred_taken(if_pred_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_word = 32'h341C_E137;
            32'h0000_0004: rom_word = 32'hF0C1_0113;
            32'h0000_0010: rom_word = 32'h3651_0113;
            32'h0000_0048: rom_word = 32'h0005_0283;
            32'h0000_0064: rom_word = 32'hFED6_42E3;
            default:       rom_word = {a[15:0], 16'h0013};
        endcase
    endfunction

    always_comb rom_data = rom_word(rom_addr);

    // Normal fetch of exp_pc: queue the IF/ID contents and advance the expected PC.
    function automatic void push_fetch(input bit pred);
        exp_q.push_back({exp_pc, rom_word(exp_pc), 1'b1, pred});
        exp_pc = pred ? 32'h0000_0048 : exp_pc + 32'd4;
    endfunction

    function automatic void push_bubble(input logic [31:0] target);
        exp_q.push_back({exp_pc, NOP, 1'b0, 1'b0});
        exp_pc = {target[31:2], 2'b00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [65:0] got;
        logic [65:0] exp;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = {32'h0, NOP, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_ifid: got %h expected %h", got, exp);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rom_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_rom_addr: got %h expected %h", rom_addr, 32'h0);
        end
        exp_pc = 32'h0;
    endtask

    task automatic test_sequential();
        logic [65:0] got;
        logic [65:0] exp;
        for (int i = 0; i < 5; i++) begin
            push_fetch(1'b0);
            step();
            got = {if_pc, if_inst, if_valid, if_pred_taken};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL seq_%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [65:0] got;
        logic [65:0] exp;
        exp = {32'h10, 32'h3651_0113, 1'b1, 1'b0};
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {if_pc, if_inst, if_valid, if_pred_taken};
            checks++;
            if (got !== exp || rom_addr !== 32'h14) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h rom_addr %h expected %h rom_addr 14",
                         i, got, rom_addr, exp);
            end
        end
        stall = 1'b0;
        push_fetch(1'b0);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stall_release: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_redirect();
        logic [65:0] got;
        logic [65:0] exp;
        redirect = 1'b1; redirect_pc = 32'h6C;
        push_bubble(32'h6C);
        step();
        redirect_pc = 32'h48;
        push_bubble(32'h48);
        step();
        redirect = 1'b0;
        push_fetch(1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            got = exp_q.pop_front();
            exp = got;
        end
        // Only the last entry is still observable; earlier ones checked via rom_addr below.
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        checks++;
        if (got !== exp || if_inst !== 32'h0005_0283 || if_pc !== 32'h48) begin
            errors++;
            $display("FAIL redirect_target: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_redirect_bubble();
        logic [65:0] got;
        logic [65:0] exp;
        redirect = 1'b1; redirect_pc = 32'h6C;
        push_bubble(32'h6C);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || rom_addr !== 32'h6C) begin
            errors++;
            $display("FAIL redirect_bubble1: got %h rom_addr %h expected %h rom_addr 6c",
                     got, rom_addr, exp);
        end
        redirect_pc = 32'h48;
        push_bubble(32'h48);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || if_inst !== NOP || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_bubble2: got %h expected %h", got, exp);
        end
        redirect = 1'b0;
        push_fetch(1'b0);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL redirect_after: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_predict();
        logic [65:0] got;
        logic [65:0] exp;
        redirect = 1'b1; redirect_pc = 32'h64;
        push_bubble(32'h64);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL predict_setup: got %h expected %h", got, exp);
        end
        redirect = 1'b0;
        push_fetch(PredEn);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || rom_addr !== exp_pc) begin
            errors++;
            $display("FAIL predict_branch: got %h rom_addr %h expected %h rom_addr %h",
                     got, rom_addr, exp, exp_pc);
        end
        push_fetch(1'b0);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL predict_next: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_redirect_stall();
        logic [65:0] got;
        logic [65:0] exp;
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h8E;
        push_bubble(32'h8E);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || rom_addr !== 32'h8C) begin
            errors++;
            $display("FAIL redir_stall: got %h rom_addr %h expected %h rom_addr 8c",
                     got, rom_addr, exp);
        end
        redirect = 1'b0;
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        checks++;
        if (got !== exp || rom_addr !== 32'h8C) begin
            errors++;
            $display("FAIL redir_stall_hold: got %h rom_addr %h expected %h rom_addr 8c",
                     got, rom_addr, exp);
        end
        stall = 1'b0;
        push_fetch(1'b0);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL redir_stall_release: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_wrap();
        logic [65:0] got;
        logic [65:0] exp;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        push_bubble(32'hFFFF_FFFC);
        step();
        void'(exp_q.pop_front());
        redirect = 1'b0;
        checks++;
        if (rom_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_top: got %h expected fffffffc", rom_addr);
        end
        push_fetch(1'b0);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || rom_addr !== 32'h0 || exp_pc !== rom_addr) begin
            errors++;
            $display("FAIL wrap: got %h rom_addr %h expected %h rom_addr 0", got, rom_addr, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [65:0] got;
        logic [65:0] exp;
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = {32'h0, NOP, 1'b0, 1'b0};
        checks++;
        if (got !== exp || rom_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h rom_addr %h expected %h rom_addr 0",
                     got, rom_addr, exp);
        end
        rst = 1'b0; redirect = 1'b0;
        exp_pc = 32'h0;
        push_fetch(1'b0);
        step();
        got = {if_pc, if_inst, if_valid, if_pred_taken};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || if_inst !== 32'h341C_E137) begin
            errors++;
            $display("FAIL reset_mid_restart: got %h expected %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_bubble();
        test_predict();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
